// File: rtl/execute_stage_multi.sv
// Execute stage with LANES parallel ALU lanes and a fixed-latency multiply.
// A bundle that holds a valid MUL is parked in holding registers. Its results
// are released together MUL_LAT edges after the bundle was accepted, so no lane
// overtakes the multiply and bundle order is kept.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | a new bundle is accepted on every edge that has no stall/flush
//   MUL_BUSY | a MUL bundle is held; cnt counts down to its release
module execute_stage_multi #(
    parameter int LANES   = 2,
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall_E,
    input  logic                  flush_E,
    output logic                  busy_E,
    input  logic [LANES-1:0]      lane_valid,
    input  logic [4*LANES-1:0]    alu_op,
    input  logic [XLEN*LANES-1:0] rdata1,
    input  logic [XLEN*LANES-1:0] rdata2,
    input  logic [XLEN*LANES-1:0] imm,
    input  logic [LANES-1:0]      use_imm,
    input  logic [LANES-1:0]      mem_read,
    input  logic [LANES-1:0]      mem_write,
    input  logic [LANES-1:0]      reg_write,
    input  logic [5*LANES-1:0]    rd,
    output logic [LANES-1:0]      lane_valid_out,
    output logic [XLEN*LANES-1:0] alu_res,
    output logic [XLEN*LANES-1:0] wdata,
    output logic [LANES-1:0]      mem_read_out,
    output logic [LANES-1:0]      mem_write_out,
    output logic [LANES-1:0]      reg_write_out,
    output logic [5*LANES-1:0]    rd_out
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(MUL_LAT);
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [LANES-1:0]        hold_valid, hold_mr, hold_mw, hold_rw;
    logic [4*LANES-1:0]      hold_op;
    logic [XLEN*LANES-1:0]   hold_a, hold_b, hold_wd;
    logic [5*LANES-1:0]      hold_rd;

    logic [XLEN-1:0]         opb      [LANES];
    logic [XLEN-1:0]         in_res   [LANES];
    logic [XLEN-1:0]         hold_res [LANES];
    logic                    mul_hit;

    function automatic logic [XLEN-1:0] alu_eval(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] res;
        sh  = b[SHW-1:0];
        res = '0;
        case (op)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a ^ b;
            4'd5:    res = a << sh;
            4'd6:    res = a >> sh;
            4'd7:    res[0] = ($signed(a) < $signed(b));
            4'd8:    res = $unsigned($signed(a) >>> sh);
            4'd9:    res[0] = (a < b);
            4'd10:   res = a * b;
            default: res = '0;
        endcase
        return res;
    endfunction

    assign busy_E = (state == MUL_BUSY) | stall_E;

    // Per-lane operand select, results for the live and the held bundle, MUL detect
    always_comb begin
        mul_hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            opb[k]      = use_imm[k] ? imm[k*XLEN +: XLEN] : rdata2[k*XLEN +: XLEN];
            in_res[k]   = alu_eval(alu_op[4*k +: 4], rdata1[k*XLEN +: XLEN], opb[k]);
            hold_res[k] = alu_eval(hold_op[4*k +: 4], hold_a[k*XLEN +: XLEN],
                                   hold_b[k*XLEN +: XLEN]);
            if (lane_valid[k] && (alu_op[4*k +: 4] == OP_MUL))
                mul_hit = 1'b1;
        end
    end

    // Sequencing FSM, multiply countdown, holding registers and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            hold_valid     <= '0;
            hold_mr        <= '0;
            hold_mw        <= '0;
            hold_rw        <= '0;
            hold_op        <= '0;
            hold_a         <= '0;
            hold_b         <= '0;
            hold_wd        <= '0;
            hold_rd        <= '0;
            lane_valid_out <= '0;
            alu_res        <= '0;
            wdata          <= '0;
            mem_read_out   <= '0;
            mem_write_out  <= '0;
            reg_write_out  <= '0;
            rd_out         <= '0;
        end else if (flush_E) begin
            // Kill whatever is in flight. Data outputs are left as they are.
            state          <= IDLE;
            cnt            <= '0;
            lane_valid_out <= '0;
            mem_read_out   <= '0;
            mem_write_out  <= '0;
            reg_write_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall_E) begin
                        if (mul_hit) begin
                            hold_valid     <= lane_valid;
                            hold_mr        <= mem_read;
                            hold_mw        <= mem_write;
                            hold_rw        <= reg_write;
                            hold_op        <= alu_op;
                            hold_a         <= rdata1;
                            hold_wd        <= rdata2;
                            hold_rd        <= rd;
                            for (int k = 0; k < LANES; k++)
                                hold_b[k*XLEN +: XLEN] <= opb[k];
                            cnt            <= CW'(MUL_LAT - 1);
                            state          <= MUL_BUSY;
                            lane_valid_out <= '0;
                            mem_read_out   <= '0;
                            mem_write_out  <= '0;
                            reg_write_out  <= '0;
                        end else begin
                            lane_valid_out <= lane_valid;
                            mem_read_out   <= mem_read & lane_valid;
                            mem_write_out  <= mem_write & lane_valid;
                            reg_write_out  <= reg_write & lane_valid;
                            rd_out         <= rd;
                            wdata          <= rdata2;
                            for (int k = 0; k < LANES; k++)
                                alu_res[k*XLEN +: XLEN] <= in_res[k];
                        end
                    end
                end
                MUL_BUSY: begin
                    // The countdown runs even while stalled. Only the release waits for the stall to drop.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!stall_E) begin
                        lane_valid_out <= hold_valid;
                        mem_read_out   <= hold_mr & hold_valid;
                        mem_write_out  <= hold_mw & hold_valid;
                        reg_write_out  <= hold_rw & hold_valid;
                        rd_out         <= hold_rd;
                        wdata          <= hold_wd;
                        for (int k = 0; k < LANES; k++)
                            alu_res[k*XLEN +: XLEN] <= hold_res[k];
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_multi.sv
// Scoreboard bench for execute_stage_multi (LANES=2, XLEN=32, MUL_LAT=3).
// The stimulus pushes the expected bundle and the cycle in which it must
// appear. The monitor pops one entry each time a new valid bundle is presented.
module tb_execute_stage_multi;

    localparam int LANES   = 2;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 3;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  stall_E, flush_E, busy_E;
    logic [LANES-1:0]      lane_valid, use_imm, mem_read, mem_write, reg_write;
    logic [4*LANES-1:0]    alu_op;
    logic [XLEN*LANES-1:0] rdata1, rdata2, imm;
    logic [5*LANES-1:0]    rd;
    logic [LANES-1:0]      lane_valid_out, mem_read_out, mem_write_out, reg_write_out;
    logic [XLEN*LANES-1:0] alu_res, wdata;
    logic [5*LANES-1:0]    rd_out;

    execute_stage_multi #(.LANES(LANES), .XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .stall_E(stall_E), .flush_E(flush_E),
        .busy_E(busy_E), .lane_valid(lane_valid), .alu_op(alu_op),
        .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .use_imm(use_imm),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .rd(rd), .lane_valid_out(lane_valid_out), .alu_res(alu_res),
        .wdata(wdata), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .reg_write_out(reg_write_out),
        .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  v;
        logic [63:0] res;
        logic [63:0] wd;
        logic [1:0]  mr;
        logic [1:0]  mw;
        logic [1:0]  rw;
        logic [9:0]  rdv;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic stall_prev = 1'b0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        stall_prev <= stall_E;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: a bundle is new when the last edge was not stalled and some lane is valid
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && !stall_prev && lane_valid_out != '0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got valid=%b res=%h expected no output (cycle %0d)",
                         lane_valid_out, alu_res, cyc);
            end else begin
                e = sb.pop_front();
                check("out_cycle", 64'(cyc), 64'(e.cyc));
                check("lane_valid_out", 64'(lane_valid_out), 64'(e.v));
                check("alu_res", alu_res, e.res);
                check("wdata", wdata, e.wd);
                check("mem_read_out", 64'(mem_read_out), 64'(e.mr));
                check("mem_write_out", 64'(mem_write_out), 64'(e.mw));
                check("reg_write_out", 64'(reg_write_out), 64'(e.rw));
                check("rd_out", 64'(rd_out), 64'(e.rdv));
            end
        end
    end

    task automatic clear_inputs();
        lane_valid = '0; alu_op = '0; rdata1 = '0; rdata2 = '0; imm = '0;
        use_imm = '0; mem_read = '0; mem_write = '0; reg_write = '0; rd = '0;
    endtask

    task automatic set_lane(input int k, input logic v, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] r2,
                            input logic [31:0] im, input logic ui,
                            input logic mr, input logic mw, input logic rw,
                            input logic [4:0] d);
        lane_valid[k] = v;  alu_op[4*k +: 4] = op;
        rdata1[32*k +: 32] = a;  rdata2[32*k +: 32] = r2;  imm[32*k +: 32] = im;
        use_imm[k] = ui;  mem_read[k] = mr;  mem_write[k] = mw;  reg_write[k] = rw;
        rd[5*k +: 5] = d;
    endtask

    task automatic push_exp(input int lat, input logic [1:0] v,
                            input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [1:0] mr, input logic [1:0] mw,
                            input logic [1:0] rw, input logic [4:0] d0,
                            input logic [4:0] d1);
        exp_t e;
        e.cyc = cyc + lat;  e.v = v;  e.res = {r1, r0};  e.wd = {w1, w0};
        e.mr = mr;  e.mw = mw;  e.rw = rw;  e.rdv = {d1, d0};
        sb.push_back(e);
    endtask

    logic [3:0]  t_op0[6], t_op1[6];
    logic [31:0] t_a0[6], t_b0[6], t_r0[6], t_a1[6], t_b1[6], t_r1[6];

    initial begin
        t_op0 = '{4'd2, 4'd5, 4'd7, 4'd11, 4'd1, 4'd4};
        t_a0  = '{32'hF0F0F0F0, 32'h1, 32'hFFFFFFFF, 32'h5, 32'h0, 32'hF0F0};
        t_b0  = '{32'h0FF00FF0, 32'd31, 32'h1, 32'h6, 32'h1, 32'hFF00};
        t_r0  = '{32'h00F000F0, 32'h80000000, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0FF0};
        t_op1 = '{4'd3, 4'd6, 4'd9, 4'd8, 4'd0, 4'd0};
        t_a1  = '{32'hF0000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFF0, 32'hFFFFFFFF, 32'h3};
        t_b1  = '{32'h0000000F, 32'h3F, 32'h1, 32'h4, 32'h2, 32'h4};
        t_r1  = '{32'hF000000F, 32'h1, 32'h0, 32'h07FFFFFF, 32'h1, 32'h7};

        reset_n = 1'b0; stall_E = 1'b0; flush_E = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(lane_valid_out), 64'h0);
        check("reset_alu_res", alu_res, 64'h0);
        check("reset_rw", 64'(reg_write_out), 64'h0);
        check("reset_busy", 64'(busy_E), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD 5+7 and SRA 0x80000000 by imm 4
        set_lane(0, 1, 4'd0, 32'd5, 32'd7, 32'd0, 0, 0, 0, 1, 5'd3);
        set_lane(1, 1, 4'd8, 32'h80000000, 32'h11, 32'd4, 1, 0, 0, 1, 5'd4);
        push_exp(1, 2'b11, 32'hC, 32'hF8000000, 32'h7, 32'h11, 2'b00, 2'b00, 2'b11, 5'd3, 5'd4);
        @(negedge clk);
        check("alu_busy", 64'(busy_E), 64'h0);
        clear_inputs();

        // Back-to-back ALU bundles
        for (int i = 0; i < 6; i++) begin
            set_lane(0, 1, t_op0[i], t_a0[i], t_b0[i], 32'hDEAD, 0, 0, 0, 1, 5'(2*i));
            set_lane(1, 1, t_op1[i], t_a1[i], t_b1[i], 32'hBEEF, 0, 0, 0, 1, 5'(2*i+1));
            push_exp(1, 2'b11, t_r0[i], t_r1[i], t_b0[i], t_b1[i], 2'b00, 2'b00, 2'b11,
                     5'(2*i), 5'(2*i+1));
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);

        // MUL 0xFFFF*0x10001 with SLTU 1<0xFFFFFFFF; inputs during busy are ignored
        set_lane(0, 1, 4'd10, 32'hFFFF, 32'h10001, 32'd0, 0, 0, 1, 1, 5'd5);
        set_lane(1, 1, 4'd9, 32'h1, 32'h22, 32'hFFFFFFFF, 1, 1, 0, 1, 5'd6);
        push_exp(1 + MUL_LAT, 2'b11, 32'hFFFFFFFF, 32'h1, 32'h10001, 32'h22,
                 2'b10, 2'b01, 2'b11, 5'd5, 5'd6);
        @(negedge clk);
        check("mul_busy_1", 64'(busy_E), 64'h1);
        clear_inputs();
        set_lane(0, 1, 4'd0, 32'h1, 32'h1, 32'h0, 0, 0, 0, 1, 5'd7);
        @(negedge clk);
        check("mul_busy_2", 64'(busy_E), 64'h1);
        @(negedge clk);
        check("mul_busy_3", 64'(busy_E), 64'h1);
        check("mul_bubble", 64'(lane_valid_out), 64'h0);
        clear_inputs();
        @(negedge clk);
        check("mul_done_busy", 64'(busy_E), 64'h0);

        // Same MUL with a 2-cycle stall when the counter reaches zero
        set_lane(0, 1, 4'd10, 32'hFFFF, 32'h10001, 32'd0, 0, 0, 1, 1, 5'd5);
        set_lane(1, 1, 4'd9, 32'h1, 32'h22, 32'hFFFFFFFF, 1, 1, 0, 1, 5'd6);
        push_exp(1 + MUL_LAT + 2, 2'b11, 32'hFFFFFFFF, 32'h1, 32'h10001, 32'h22,
                 2'b10, 2'b01, 2'b11, 5'd5, 5'd6);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("stall_busy_a", 64'(busy_E), 64'h1);
        @(negedge clk);
        stall_E = 1'b1;
        @(negedge clk);
        check("stall_busy_b", 64'(busy_E), 64'h1);
        check("stall_bubble", 64'(lane_valid_out), 64'h0);
        @(negedge clk);
        stall_E = 1'b0;
        #1;
        check("stall_busy_c", 64'(busy_E), 64'h1);
        @(negedge clk);
        check("stall_done_busy", 64'(busy_E), 64'h0);

        // Flush in the first MUL_BUSY cycle, then a normal bundle
        set_lane(0, 1, 4'd10, 32'h2, 32'h3, 32'd0, 0, 0, 0, 1, 5'd9);
        @(negedge clk);
        clear_inputs();
        flush_E = 1'b1;
        @(negedge clk);
        flush_E = 1'b0;
        #1;
        check("flush_busy", 64'(busy_E), 64'h0);
        check("flush_valid", 64'(lane_valid_out), 64'h0);
        set_lane(0, 1, 4'd0, 32'h10, 32'h99, 32'h20, 1, 1, 0, 1, 5'd10);
        set_lane(1, 1, 4'd4, 32'hF0F0, 32'hFF00, 32'h0, 0, 0, 0, 0, 5'd11);
        push_exp(1, 2'b11, 32'h30, 32'h0FF0, 32'h99, 32'hFF00, 2'b01, 2'b00, 2'b01, 5'd10, 5'd11);
        @(negedge clk);
        clear_inputs();
        repeat (5) @(negedge clk);

        // Lane 1 invalid with a MUL op: no busy, its control bits are gated off
        set_lane(0, 1, 4'd1, 32'd10, 32'd3, 32'd0, 0, 0, 0, 1, 5'd12);
        set_lane(1, 0, 4'd10, 32'd3, 32'd4, 32'd0, 0, 0, 1, 1, 5'd13);
        push_exp(1, 2'b01, 32'h7, 32'hC, 32'h3, 32'h4, 2'b00, 2'b00, 2'b01, 5'd12, 5'd13);
        @(negedge clk);
        check("invalid_mul_busy", 64'(busy_E), 64'h0);
        clear_inputs();
        @(negedge clk);

        // Two MUL lanes complete together
        set_lane(0, 1, 4'd10, 32'h12345678, 32'h10, 32'd0, 0, 0, 0, 1, 5'd14);
        set_lane(1, 1, 4'd10, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1, 5'd15);
        push_exp(1 + MUL_LAT, 2'b11, 32'h23456780, 32'h1, 32'h10, 32'h0,
                 2'b00, 2'b00, 2'b11, 5'd14, 5'd15);
        @(negedge clk);
        clear_inputs();
        repeat (MUL_LAT + 1) @(negedge clk);

        // Reset in the middle of a MUL: nothing may come out afterwards
        set_lane(0, 1, 4'd10, 32'h5, 32'h5, 32'd0, 0, 0, 0, 1, 5'd16);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_alu_res", alu_res, 64'h0);
        check("rst_mid_busy", 64'(busy_E), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_rel_busy", 64'(busy_E), 64'h0);
        check("rst_rel_valid", 64'(lane_valid_out), 64'h0);
        repeat (6) @(negedge clk);

        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_stage_multi.md
Name: execute_stage_multi

Overview:
- Parametrised N-lane successor of the dual-issue execute stage.
- Performs per-lane ALU operations on decoded operands and registers the results plus control into the Execute->Mem/WB pipeline register.
- Adds SRA, SLTU and a fixed-latency multi-cycle MUL with an in-order bundle hold and a busy handshake to decode.
- Adds per-lane valid bits and a flush input.

Parameters:
- LANES, 2, number of issue lanes (1..4).
- XLEN, 32, datapath width (power of two, >=8).
- MUL_LAT, 3, cycles from bundle accept to MUL result at outputs (>=2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_E  in  1  downstream stall; output register holds.
- flush_E  in  1  kill the in-flight bundle.
- busy_E  out  1  decode must hold the current bundle.
- lane_valid  in  LANES  per-lane instruction valid.
- alu_op  in  4*LANES  per-lane op; lane k at [4k+3:4k].
- rdata1  in  XLEN*LANES  per-lane rs1 value.
- rdata2  in  XLEN*LANES  per-lane rs2 value.
- imm  in  XLEN*LANES  per-lane immediate.
- use_imm  in  LANES  1 = operand B is imm, 0 = operand B is rs2.
- mem_read, mem_write, reg_write  in  LANES each  control bits.
- rd  in  5*LANES  destination register.
- lane_valid_out  out  LANES  result valid.
- alu_res  out  XLEN*LANES  result or memory address.
- wdata  out  XLEN*LANES  store data (rs2).
- mem_read_out, mem_write_out, reg_write_out  out  LANES each  control, gated by lane valid.
- rd_out  out  5*LANES  destination register.

Behaviour:
- Reset (reset_n low, async): every output register 0, FSM to IDLE, counter 0, holding registers 0. Reset mid-MUL aborts the operation with no output.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (all modulo 2^XLEN).
  - 5 SLL, 6 SRL, 8 SRA; shift amount is B[$clog2(XLEN)-1:0].
  - 7 SLT signed, 9 SLTU unsigned; result 1 or 0, zero-extended.
  - 10 MUL: low XLEN bits of A*B.
  - 11..15: result 0.
- A = rdata1 lane value; B = imm if use_imm else rdata2.
- busy_E = (state==MUL_BUSY) | stall_E, combinational.
- Accept: in IDLE with !stall_E and !flush_E, the bundle is accepted every cycle. All-invalid bundles are accepted as bubbles.
- ALU-only accept (no valid lane has op 10): outputs load on the same edge, latency 1.
  - lane_valid_out = lane_valid.
  - Control outputs = control inputs AND lane_valid.
  - alu_res and wdata load regardless of valid.
- MUL accept (any valid lane has op 10):
  - Whole bundle captured into holding registers, including ALU lanes.
  - Counter loads MUL_LAT-1; state goes to MUL_BUSY.
  - lane_valid_out and all control outputs clear to 0 on the accept edge (bubble).
- MUL_BUSY:
  - Counter decrements each cycle while nonzero, independent of stall_E.
  - When counter==0 and !stall_E: outputs load from the holding registers with all lanes evaluated, state returns to IDLE.
  - When counter==0 and stall_E: remain in MUL_BUSY with counter 0.
  - Total latency from accept edge to valid outputs is exactly MUL_LAT cycles when unstalled.
  - Bundle order is preserved; no lane bypasses the MUL.
- stall_E in IDLE: all outputs hold, nothing accepted.
- flush_E (priority over stall_E and accept):
  - lane_valid_out and control outputs clear to 0; data outputs hold.
  - FSM to IDLE, counter 0; the incoming bundle is not accepted that cycle.
  - busy_E drops the next cycle unless stall_E is asserted.
- Simultaneous MUL completion and flush_E: flush wins; no results emitted.
- Multiple MUL lanes in one bundle complete together.

Test Plan:
- Reset low mid-MUL, then release -> all outputs 0, busy_E=0 on the next cycle, no stale result.
- LANES=2: lane0 ADD 5+7, lane1 SRA 0x80000000 by imm 4 -> one cycle later alu_res = 12 and 0xF8000000, lane_valid_out=2'b11, busy_E=0.
- MUL_LAT=3: lane0 MUL 0xFFFF*0x10001, lane1 SLTU 1<0xFFFFFFFF -> busy_E high 3 cycles; results 0xFFFFFFFF and 1 appear exactly 3 edges after accept; bubble (valid 0) in between.
- Same MUL with stall_E high at counter==0 for 2 cycles -> outputs deferred 2 cycles, then correct; busy_E high throughout.
- flush_E asserted at cycle 1 of MUL_BUSY -> no result, lane_valid_out stays 0, IDLE next cycle, next ADD bundle accepted normally.
- lane_valid=2'b01 with lane1 reg_write=1 and op 10 -> reg_write_out[1]=0, lane1 MUL ignored, latency 1 (no busy).
